// File: rtl/paddle_motion_ctrl.sv
// paddle_motion_ctrl: two-paddle 60 Hz motion with hold-to-accelerate, edge clamps and optional CPU paddle 2 (PADDLE_CPU_EN)
module paddle_motion_ctrl #(
    parameter int P1_X        = 5,
    parameter int P2_X        = 155,
    parameter int Y_START     = 75,
    parameter int Y_MIN       = 31,
    parameter int Y_MAX       = 119,
    parameter int PADDLE_LEN  = 20,
    parameter int SLOW_STEP   = 1,
    parameter int FAST_STEP   = 2,
    parameter int ACCEL_TICKS = 15,
    parameter int CPU_PERIOD  = 4,
    parameter int CPU_DEAD    = 2
) (
    input  logic       sixtyhz_clk,
    input  logic       resetn,
    input  logic       freeze,
    input  logic       inc_p1_y,
    input  logic       dec_p1_y,
    input  logic       inc_p2_y,
    input  logic       dec_p2_y,
    input  logic       cpu,
    input  logic [6:0] b_y,
    output logic [7:0] paddle1_x,
    output logic [6:0] paddle1_y,
    output logic [7:0] paddle2_x,
    output logic [6:0] paddle2_y,
    output logic       p1_at_top,
    output logic       p1_at_bot,
    output logic       p2_at_top,
    output logic       p2_at_bot
);
    typedef enum logic [1:0] {IDLE, SLOW, FAST} state_t;
    typedef enum logic [1:0] {NONE, UP, DOWN} dir_t;
    typedef struct packed {
        state_t     st;
        dir_t       dir;
        logic [4:0] hc;
        logic [6:0] y;
    } pad_t;

    localparam logic [6:0] YTOP = 7'(Y_MIN);
    localparam logic [6:0] YBOT = 7'(Y_MAX - PADDLE_LEN);
    localparam pad_t RST = '{st: IDLE, dir: NONE, hc: 5'd0, y: 7'(Y_START)};

    function automatic dir_t decode(input logic inc, input logic dec);
        return inc ? DOWN : dec ? UP : NONE;
    endfunction

    function automatic pad_t advance(input pad_t p, input dir_t cmd, input logic slow_only);
        pad_t n;
        logic [7:0] step;
        logic [7:0] sum;
        n = p;
        step = '0;
        sum = '0;
        if (cmd == NONE) begin
            n.st = IDLE;
            n.hc = '0;
        end else begin
            if (p.st == IDLE || cmd != p.dir) begin
                n.st = SLOW;
                n.hc = 5'd1;
            end else begin
                n.hc = (&p.hc) ? p.hc : p.hc + 5'd1;
                if (p.st == SLOW && n.hc > 5'(ACCEL_TICKS) && !slow_only)
                    n.st = FAST;
            end
            n.dir = cmd;
            step = (n.st == FAST) ? 8'(FAST_STEP) : 8'(SLOW_STEP);
            // Unsigned 8-bit math with headroom so the clamps never see a wrapped value
            if (cmd == DOWN) begin
                sum = {1'b0, p.y} + step;
                n.y = (sum > {1'b0, YBOT}) ? YBOT : sum[6:0];
            end else begin
                sum = {1'b0, p.y} - step;
                n.y = ({1'b0, p.y} < {1'b0, YTOP} + step) ? YTOP : sum[6:0];
            end
        end
        return n;
    endfunction

    pad_t p1, p2, p1_n, p2_n;
    dir_t cmd2;
    logic slow2;

`ifdef PADDLE_CPU_EN
    localparam int DW = (CPU_PERIOD > 1) ? $clog2(CPU_PERIOD) : 1;
    logic [DW-1:0] div, div_n;
    dir_t ccmd, ccmd_n, cpu_dir;
    logic cpu_q, toggle;
    logic [7:0] ctr;

    always_comb begin
        ctr = {1'b0, p2.y} + 8'(PADDLE_LEN / 2);
        cpu_dir = ({1'b0, b_y} + 8'(CPU_DEAD) < ctr) ? UP :
                  ({1'b0, b_y} > ctr + 8'(CPU_DEAD)) ? DOWN : NONE;
        toggle = cpu != cpu_q;
        div_n = toggle ? '0 :
                (freeze || !cpu) ? div :
                (div == DW'(CPU_PERIOD - 1)) ? '0 : div + DW'(1);
        ccmd_n = toggle ? NONE : (freeze || !cpu || div != '0) ? ccmd : cpu_dir;
        cmd2 = toggle ? NONE :
               cpu ? ((div == '0) ? cpu_dir : ccmd) : decode(inc_p2_y, dec_p2_y);
        slow2 = cpu;
    end

    always_ff @(posedge sixtyhz_clk) begin
        if (!resetn) begin
            div <= '0;
            ccmd <= NONE;
            cpu_q <= 1'b0;
        end else begin
            div <= div_n;
            ccmd <= ccmd_n;
            cpu_q <= cpu;
        end
    end
`else
    logic unused;
    assign unused = ^{cpu, b_y};

    always_comb begin
        cmd2 = decode(inc_p2_y, dec_p2_y);
        slow2 = 1'b0;
    end
`endif

    always_comb begin
        p1_n = advance(p1, freeze ? NONE : decode(inc_p1_y, dec_p1_y), 1'b0);
        p2_n = advance(p2, freeze ? NONE : cmd2, slow2);
    end

    always_ff @(posedge sixtyhz_clk) begin
        if (!resetn) begin
            p1 <= RST;
            p2 <= RST;
            p1_at_top <= RST.y == YTOP;
            p1_at_bot <= RST.y == YBOT;
            p2_at_top <= RST.y == YTOP;
            p2_at_bot <= RST.y == YBOT;
        end else begin
            p1 <= p1_n;
            p2 <= p2_n;
            p1_at_top <= p1_n.y == YTOP;
            p1_at_bot <= p1_n.y == YBOT;
            p2_at_top <= p2_n.y == YTOP;
            p2_at_bot <= p2_n.y == YBOT;
        end
    end

    assign paddle1_x = 8'(P1_X);
    assign paddle2_x = 8'(P2_X);
    assign paddle1_y = p1.y;
    assign paddle2_y = p2.y;
endmodule

// File: tb/tb_paddle_motion_ctrl.sv
// tb_paddle_motion_ctrl: directed stimulus with a queue-based scoreboard for paddle_motion_ctrl (CPU section under PADDLE_CPU_EN)
module tb_paddle_motion_ctrl;
    logic sixtyhz_clk = 1'b0;
    logic resetn, freeze, inc_p1_y, dec_p1_y, inc_p2_y, dec_p2_y, cpu;
    logic [6:0] b_y;
    logic [7:0] paddle1_x, paddle2_x;
    logic [6:0] paddle1_y, paddle2_y;
    logic p1_at_top, p1_at_bot, p2_at_top, p2_at_bot;

    typedef struct {
        logic [6:0] y1;
        logic [6:0] y2;
        string      tag;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    always #5 sixtyhz_clk = ~sixtyhz_clk;

    paddle_motion_ctrl dut (
        .sixtyhz_clk(sixtyhz_clk),
        .resetn(resetn),
        .freeze(freeze),
        .inc_p1_y(inc_p1_y),
        .dec_p1_y(dec_p1_y),
        .inc_p2_y(inc_p2_y),
        .dec_p2_y(dec_p2_y),
        .cpu(cpu),
        .b_y(b_y),
        .paddle1_x(paddle1_x),
        .paddle1_y(paddle1_y),
        .paddle2_x(paddle2_x),
        .paddle2_y(paddle2_y),
        .p1_at_top(p1_at_top),
        .p1_at_bot(p1_at_bot),
        .p2_at_top(p2_at_top),
        .p2_at_bot(p2_at_bot)
    );

    task automatic set(input logic i1, d1, i2, d2, fz, c, input logic [6:0] by);
        inc_p1_y = i1;
        dec_p1_y = d1;
        inc_p2_y = i2;
        dec_p2_y = d2;
        freeze = fz;
        cpu = c;
        b_y = by;
    endtask

    task automatic tick(input string tag, input logic [6:0] e1, input logic [6:0] e2);
        q.push_back('{e1, e2, tag});
        @(negedge sixtyhz_clk);
    endtask

    // Monitor: one expected entry is consumed just after each rising edge
    initial begin
        exp_t e;
        logic [33:0] got, want;
        forever begin
            @(posedge sixtyhz_clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                checks++;
                got = {paddle1_y, paddle2_y, paddle1_x, paddle2_x,
                       p1_at_top, p1_at_bot, p2_at_top, p2_at_bot};
                want = {e.y1, e.y2, 8'd5, 8'd155,
                        e.y1 == 7'd31, e.y1 == 7'd99, e.y2 == 7'd31, e.y2 == 7'd99};
                if (got !== want) begin
                    failures++;
                    $display("FAIL %s: got y1=%0d y2=%0d x1=%0d x2=%0d flags=%b, want y1=%0d y2=%0d x1=5 x2=155 flags=%b",
                             e.tag, paddle1_y, paddle2_y, paddle1_x, paddle2_x, got[3:0],
                             e.y1, e.y2, want[3:0]);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, want completion");
        $fatal(1);
    end

    initial begin
        set(0, 0, 0, 0, 0, 0, 7'd0);
        resetn = 1'b0;
        tick("reset", 75, 75);
        tick("reset", 75, 75);
        resetn = 1'b1;
        set(1, 0, 0, 0, 0, 0, 7'd0);
        for (int k = 1; k <= 21; k++)
            tick("accel_down", (k <= 15) ? 7'(75 + k) : (k >= 20) ? 7'd99 : 7'(90 + 2 * (k - 15)), 75);
        set(0, 0, 0, 0, 0, 0, 7'd0);
        tick("idle_bot", 99, 75);
        set(0, 1, 0, 0, 0, 0, 7'd0);
        for (int k = 1; k <= 15; k++) tick("slow_up", 7'(99 - k), 75);
        for (int k = 1; k <= 26; k++) tick("fast_up", 7'(84 - 2 * k), 75);
        tick("clamp_top", 31, 75);
        tick("hold_top", 31, 75);
        set(1, 0, 0, 0, 0, 0, 7'd0);
        tick("reverse_fast", 32, 75);
        set(0, 0, 0, 0, 0, 0, 7'd0);
        tick("idle", 32, 75);
        set(0, 0, 1, 1, 0, 0, 7'd0);
        for (int k = 1; k <= 5; k++) tick("both_down", 32, 7'(75 + k));
        freeze = 1'b1;
        for (int k = 0; k < 3; k++) tick("freeze", 32, 80);
        freeze = 1'b0;
        tick("unfreeze", 32, 81);
        resetn = 1'b0;
        tick("mid_reset", 75, 75);
        resetn = 1'b1;
        tick("post_reset", 75, 76);
        set(0, 0, 0, 0, 0, 0, 7'd0);
        tick("idle", 75, 76);
`ifdef PADDLE_CPU_EN
        resetn = 1'b0;
        tick("cpu_reset", 75, 75);
        resetn = 1'b1;
        set(0, 0, 1, 0, 0, 1, 7'd40);
        tick("cpu_toggle_on", 75, 75);
        for (int k = 1; k <= 20; k++) tick("cpu_up", 75, 7'(75 - k));
        b_y = 7'd67;
        for (int k = 0; k < 4; k++) tick("cpu_dead_hi", 75, 55);
        b_y = 7'd68;
        for (int k = 1; k <= 4; k++) tick("cpu_down", 75, 7'(55 + k));
        b_y = 7'd67;
        for (int k = 0; k < 4; k++) tick("cpu_dead_lo", 75, 59);
        cpu = 1'b0;
        tick("cpu_toggle_off", 75, 59);
        tick("manual_after_cpu", 75, 60);
`else
        resetn = 1'b0;
        tick("nocpu_reset", 75, 75);
        resetn = 1'b1;
        set(0, 0, 1, 0, 0, 1, 7'd0);
        for (int k = 1; k <= 3; k++) tick("nocpu_manual", 75, 7'(75 + k));
`endif
        @(posedge sixtyhz_clk);
        #2;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
